alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//  Receiving end of the dispatch -> ALU reservation station interface: accepts ALU_RS_input_struct_t
//  from dispatch, holds up to RS_DEPTH entries, wakes source operands from the writeback tag bus and
//  issues the oldest fully-ready entry to one ALU pipeline over a valid/ready handshake.
//  Instantiated once per ALU (ALU_0, ALU_1) in core, between dispatch and the ALU/regfile read stage.
// PARAMETERS
//  RS_DEPTH       4   entries held; >=2; age-ordered compacting queue
//  WAKEUP_PORTS   3   writeback tag broadcast ports (ALU_0, ALU_1, LQ)
// PORTS
//  CLK                      in   1    clock, all state on posedge
//  RST                      in   1    asynchronous, active-high reset
//  dispatch_valid           in   1    dispatch_struct valid
//  dispatch_struct          in   ALU_RS_input_struct_t  op, itype, sources, dest, imm16, ROB_index
//  dispatch_ready           out  1    entry free and no kill this cycle
//  wakeup_valid             in   WAKEUP_PORTS  per-port tag valid
//  wakeup_phys_reg_tag      in   WAKEUP_PORTS x 6  per-port produced phys reg tag
//  kill_valid               in   1    squash entries younger than kill_ROB_index
//  kill_ROB_index           in   5    mispredicting instr (itself kept)
//  ROB_head_index           in   5    current ROB head, age reference
//  issue_valid              out  1    issue_* fields valid
//  issue_ready              in   1    ALU accepts this cycle
//  issue_op                 out  4    ALU_op_t
//  issue_itype              out  1    use imm16 as operand 1
//  issue_source_0/1_phys_reg_tag out 6 each  regfile read tags
//  issue_dest_phys_reg_tag  out  6
//  issue_imm16              out  16
//  issue_ROB_index          out  5
// BEHAVIOUR
//  - Reset: all entries invalid, count=0; dispatch_ready=1, issue_valid=0 (kill_valid low).
//  - Entry: valid + copy of struct; operand ok = !needed | ready.
//  - Wakeup: any port with valid & tag==source tag & needed sets ready next edge. Applies to stored
//    entries and to the entry being enqueued same cycle (dispatch struct ready OR'd with match).
//  - Eligible = valid & both operands ok, from registered bits only: wakeup->issue min 1 cycle;
//    enqueue->issue min 1 cycle (no pass-through).
//  - Select: lowest-index eligible entry (index 0 oldest). issue_* combinational from it; fire =
//    issue_valid & issue_ready. Unfired issue must hold same entry/fields unless killed.
//  - Fire removes entry; entries above shift down one. Enqueue writes slot count (or count-1 if
//    fire same cycle). Fire+enqueue at count==RS_DEPTH not possible (dispatch_ready=0 when full).
//  - dispatch_ready = (count<RS_DEPTH) & !kill_valid (registered count, no same-cycle credit).
//  - Kill: age(x) = (x - ROB_head_index) mod 32; entry with age(ROB_index) > age(kill_ROB_index)
//    invalidated at next edge; survivors compacted preserving order. Dispatch blocked on kill cycle.
//    An entry firing on the kill cycle still fires (ALU squashes by ROB); kill takes effect on rest.
//  - count = number of valid entries; 3-bit min for RS_DEPTH=4; never exceeds RS_DEPTH.
//  - RST asserted mid-operation: all entries dropped immediately, outputs to reset values.
// CONFIGURATION
//  ALU_RS_STALL_CNT_EN defined: adds port stall_count out 32 (reset 0), +1 each cycle with
//  dispatch_valid & !dispatch_ready, saturates at 32'hFFFFFFFF. Undefined: port and logic absent,
//  behaviour otherwise identical.
// TESTING
//  1 reset; dispatch ADD both sources ready, ROB 3 -> issue_valid=1 next cycle, issue_ROB_index=3.
//  2 dispatch SUB src0 tag 40 not ready; wakeup port1 tag 40 at cycle 2 -> issue_valid at cycle 3.
//  3 fill 4 entries, none ready -> dispatch_ready=0; ready entry 2, fire -> entries 3 moves to
//    slot 2, dispatch_ready=1 next cycle.
//  4 entries ROB 5,6,7 ready, issue_ready=0 two cycles -> ROB 5 held stable; then fires in order 5,6,7.
//  5 head=30, entries ROB 31,0,1; kill ROB 31 -> ROB 0,1 removed, 31 kept, count=1.
//  6 ALU_RS_STALL_CNT_EN: full RS, dispatch_valid 5 cycles -> stall_count=5.

Source files
------------

// File: rtl/alu_reservation_station.sv
// Reservation station for one ALU: age-ordered compacting queue, writeback tag wakeup, oldest-ready issue.
// Optional feature macro ALU_RS_STALL_CNT_EN adds a saturating stall_count output.
// dispatch_struct layout [47:0]: op[47:44] itype[43] src0_tag[42:37] src0_needed[36] src0_ready[35]
//   src1_tag[34:29] src1_needed[28] src1_ready[27] dest_tag[26:21] imm16[20:5] ROB_index[4:0]
module alu_reservation_station #(
    parameter int RS_DEPTH     = 4,
    parameter int WAKEUP_PORTS = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      dispatch_valid,
    input  logic [47:0]               dispatch_struct,
    output logic                      dispatch_ready,
    input  logic [WAKEUP_PORTS-1:0]   wakeup_valid,
    input  logic [WAKEUP_PORTS*6-1:0] wakeup_phys_reg_tag,
    input  logic                      kill_valid,
    input  logic [4:0]                kill_ROB_index,
    input  logic [4:0]                ROB_head_index,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [3:0]                issue_op,
    output logic                      issue_itype,
    output logic [5:0]                issue_source_0_phys_reg_tag,
    output logic [5:0]                issue_source_1_phys_reg_tag,
    output logic [5:0]                issue_dest_phys_reg_tag,
    output logic [15:0]               issue_imm16,
    output logic [4:0]                issue_ROB_index
`ifdef ALU_RS_STALL_CNT_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);

    localparam int S0_TAG = 37;
    localparam int S0_NEED = 36;
    localparam int S0_RDY = 35;
    localparam int S1_TAG = 29;
    localparam int S1_NEED = 28;
    localparam int S1_RDY = 27;

    function automatic logic tag_woken(input logic [5:0] tag,
                                       input logic [WAKEUP_PORTS-1:0] wv,
                                       input logic [WAKEUP_PORTS*6-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKEUP_PORTS; p++) begin
            if (wv[p] && (wt[p*6 +: 6] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [47:0] wake_entry(input logic [47:0] e,
                                               input logic [WAKEUP_PORTS-1:0] wv,
                                               input logic [WAKEUP_PORTS*6-1:0] wt);
        logic [47:0] r;
        r = e;
        r[S0_RDY] = e[S0_RDY] | (e[S0_NEED] & tag_woken(e[S0_TAG +: 6], wv, wt));
        r[S1_RDY] = e[S1_RDY] | (e[S1_NEED] & tag_woken(e[S1_TAG +: 6], wv, wt));
        return r;
    endfunction

    function automatic logic entry_ok(input logic [47:0] e);
        return (~e[S0_NEED] | e[S0_RDY]) & (~e[S1_NEED] | e[S1_RDY]);
    endfunction

    // ROB indices wrap at 32, so age is measured as distance from the head
    function automatic logic [4:0] age(input logic [4:0] x, input logic [4:0] head);
        return x - head;
    endfunction

    logic [47:0]         ent_q [RS_DEPTH];
    logic [47:0]         ent_n [RS_DEPTH];
    logic [RS_DEPTH-1:0] vld_q, vld_n;
    logic [CW-1:0]       count_q, count_n;
    logic                hold_q, hold_n;
    logic [IW-1:0]       hold_idx_q;
    logic [RS_DEPTH-1:0] elig, kill_hit;
    logic                sel_found, fire, enq;
    logic [IW-1:0]       sel;
    logic [CW-1:0]       wp;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            elig[i]     = vld_q[i] & entry_ok(ent_q[i]);
            kill_hit[i] = kill_valid &
                          (age(ent_q[i][4:0], ROB_head_index) > age(kill_ROB_index, ROB_head_index));
        end
    end

    // A stalled issue keeps its entry even if an older one wakes meanwhile
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        if (hold_q && elig[hold_idx_q]) begin
            sel_found = 1'b1;
            sel       = hold_idx_q;
        end else begin
            for (int i = RS_DEPTH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    sel_found = 1'b1;
                    sel       = IW'(i);
                end
            end
        end
    end

    assign issue_valid                 = sel_found;
    assign issue_op                    = sel_found ? ent_q[sel][47:44]      : '0;
    assign issue_itype                 = sel_found ? ent_q[sel][43]         : 1'b0;
    assign issue_source_0_phys_reg_tag = sel_found ? ent_q[sel][S0_TAG +: 6] : '0;
    assign issue_source_1_phys_reg_tag = sel_found ? ent_q[sel][S1_TAG +: 6] : '0;
    assign issue_dest_phys_reg_tag     = sel_found ? ent_q[sel][26:21]      : '0;
    assign issue_imm16                 = sel_found ? ent_q[sel][20:5]       : '0;
    assign issue_ROB_index             = sel_found ? ent_q[sel][4:0]        : '0;

    assign fire           = sel_found & issue_ready;
    assign dispatch_ready = (count_q < DEPTH_C) & ~kill_valid;
    assign enq            = dispatch_valid & dispatch_ready;
    assign hold_n         = sel_found & ~issue_ready & ~kill_hit[sel];

    // Survivors slide down in order; the new entry lands right after them
    always_comb begin
        wp    = '0;
        vld_n = '0;
        for (int i = 0; i < RS_DEPTH; i++) ent_n[i] = ent_q[i];
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (vld_q[i] && !(fire && (sel == IW'(i))) && !kill_hit[i]) begin
                ent_n[wp[IW-1:0]] = wake_entry(ent_q[i], wakeup_valid, wakeup_phys_reg_tag);
                vld_n[wp[IW-1:0]] = 1'b1;
                wp = wp + CW'(1);
            end
        end
        if (enq) begin
            ent_n[wp[IW-1:0]] = wake_entry(dispatch_struct, wakeup_valid, wakeup_phys_reg_tag);
            vld_n[wp[IW-1:0]] = 1'b1;
            wp = wp + CW'(1);
        end
        count_n = wp;
    end

    // Stage boundary: control state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q      <= '0;
            count_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            vld_q      <= vld_n;
            count_q    <= count_n;
            hold_q     <= hold_n;
            hold_idx_q <= sel;
        end
    end

    // Stage boundary: entry payload, qualified by vld_q
    always_ff @(posedge CLK) begin
        for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_n[i];
    end

`ifdef ALU_RS_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (dispatch_valid && !dispatch_ready) begin
            stall_count <= sat_inc32(stall_count);
        end
    end
`endif

endmodule
